// File: rtl/color_reg_pkg.sv
// Shared constants, FSM state type and lane helpers for the colour register writer.
package color_reg_pkg;

    localparam logic [1:0] SEL_INDEX = 2'd0;
    localparam logic [1:0] SEL_R     = 2'd1;
    localparam logic [1:0] SEL_G     = 2'd2;
    localparam logic [1:0] SEL_B     = 2'd3;

    localparam int unsigned LANE_R_LSB = 16;
    localparam int unsigned LANE_G_LSB = 8;
    localparam int unsigned LANE_B_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_MRG,
        ST_WR
    } state_e;

    // Replace one byte lane of a colour word; SEL_INDEX leaves the word untouched.
    function automatic logic [23:0] lane_merge(input logic [23:0] word,
                                               input logic [1:0]  sel,
                                               input logic [7:0]  b);
        logic [23:0] w;
        w = word;
        case (sel)
            SEL_R:   w[LANE_R_LSB +: 8] = b;
            SEL_G:   w[LANE_G_LSB +: 8] = b;
            SEL_B:   w[LANE_B_LSB +: 8] = b;
            default: w = word;
        endcase
        return w;
    endfunction

    function automatic logic [7:0] lane_pick(input logic [23:0] word,
                                             input logic [1:0]  sel);
        logic [7:0] b;
        case (sel)
            SEL_R:   b = word[LANE_R_LSB +: 8];
            SEL_G:   b = word[LANE_G_LSB +: 8];
            SEL_B:   b = word[LANE_B_LSB +: 8];
            default: b = '0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/color_reg_writer_if.sv
// CPU access bus plus colour RAM port A, seen from the writer (slave) and its environment (master).
interface color_reg_writer_if #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 24
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [1:0]            cpu_sel;
    logic [7:0]            cpu_din;
    logic                  cpu_busy;
    logic [7:0]            cpu_dout;
    logic                  cpu_dout_valid;
    logic                  cpu_overrun;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout;

    modport master (
        output cpu_req, cpu_we, cpu_sel, cpu_din, ram_dout,
        input  cpu_busy, cpu_dout, cpu_dout_valid, cpu_overrun,
        input  ram_we, ram_addr, ram_din
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_sel, cpu_din, ram_dout,
        output cpu_busy, cpu_dout, cpu_dout_valid, cpu_overrun,
        output ram_we, ram_addr, ram_din
    );
endinterface

// File: rtl/color_reg_writer.sv
// Byte-wide CPU access to the 16x24 colour RAM via read-modify-write on port A.
module color_reg_writer
    import color_reg_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 24
) (
    input  logic               clk_dot4x,
    input  logic               rst,
    color_reg_writer_if.slave  bus
);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] index_q;
    logic [ADDR_WIDTH-1:0] index_d;
    logic                  auto_inc_q;
    logic [1:0]            sel_q;
    logic                  we_q;
    logic [7:0]            din_q;
    logic                  busy_q;
    logic [7:0]            dout_q;
    logic                  dout_valid_q;
    logic                  overrun_q;
    logic                  ram_we_q;
    logic [DATA_WIDTH-1:0] ram_din_q;

    assign index_d = index_q + 1'b1;

    always_ff @(posedge clk_dot4x or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            index_q      <= '0;
            auto_inc_q   <= 1'b0;
            sel_q        <= SEL_INDEX;
            we_q         <= 1'b0;
            din_q        <= '0;
            busy_q       <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_din_q    <= '0;
        end else begin
            dout_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.cpu_req) begin
                        if (bus.cpu_sel == SEL_INDEX) begin
                            if (bus.cpu_we) begin
                                index_q    <= bus.cpu_din[ADDR_WIDTH-1:0];
                                auto_inc_q <= bus.cpu_din[7];
                                overrun_q  <= 1'b0;
                            end else begin
                                dout_q       <= {auto_inc_q, 3'b000, index_q};
                                dout_valid_q <= 1'b1;
                            end
                        end else begin
                            sel_q   <= bus.cpu_sel;
                            we_q    <= bus.cpu_we;
                            din_q   <= bus.cpu_din;
                            busy_q  <= 1'b1;
                            state_q <= ST_RD;
                        end
                    end
                end
                ST_RD: state_q <= ST_MRG;
                ST_MRG: begin
                    if (!we_q) begin
                        dout_q       <= lane_pick(bus.ram_dout, sel_q);
                        dout_valid_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= ST_IDLE;
                    end else begin
                        ram_din_q <= lane_merge(bus.ram_dout, sel_q, din_q);
                        ram_we_q  <= 1'b1;
                        state_q   <= ST_WR;
                    end
                end
                ST_WR: begin
                    ram_we_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                    if (sel_q == SEL_B && auto_inc_q) index_q <= index_d;
                end
                default: state_q <= ST_IDLE;
            endcase
            // Requests during an access are dropped; only the sticky flag records them.
            if (busy_q && bus.cpu_req) overrun_q <= 1'b1;
        end
    end

    assign bus.cpu_busy       = busy_q;
    assign bus.cpu_dout       = dout_q;
    assign bus.cpu_dout_valid = dout_valid_q;
    assign bus.cpu_overrun    = overrun_q;
    assign bus.ram_we         = ram_we_q;
    assign bus.ram_addr       = index_q;
    assign bus.ram_din        = ram_din_q;

endmodule

// File: tb/tb_color_reg_writer.sv
// Scoreboard bench for color_reg_writer with a 1-cycle-latency RAM model on port A.
module tb_color_reg_writer;

    typedef struct {
        logic [3:0]  addr;
        logic [23:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    color_reg_writer_if #(.ADDR_WIDTH(4), .DATA_WIDTH(24)) bus ();

    color_reg_writer #(.ADDR_WIDTH(4), .DATA_WIDTH(24)) dut (
        .clk_dot4x (clk),
        .rst       (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // RAM port A model, with a preload path used only while setting up entries
    logic [23:0] mem [16];
    logic [23:0] rd_q;
    logic        pre_en = 1'b0;
    logic [3:0]  pre_addr = '0;
    logic [23:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
        rd_q <= mem[bus.ram_addr];
    end
    assign bus.ram_dout = rd_q;

    int tests = 0;
    int failed = 0;
    int we_count = 0;

    logic [7:0] exp_rd [$];
    wr_t        exp_wr [$];

    logic [23:0] m_mem [16];
    logic [3:0]  m_idx = '0;
    logic        m_auto = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.cpu_dout_valid) begin
                check_eq("rd_pending", 32'(exp_rd.size() > 0), 32'd1);
                if (exp_rd.size() > 0) check_eq("rd_data", {24'd0, bus.cpu_dout}, {24'd0, exp_rd.pop_front()});
            end
            if (bus.ram_we) begin
                wr_t e;
                we_count++;
                check_eq("wr_pending", 32'(exp_wr.size() > 0), 32'd1);
                if (exp_wr.size() > 0) begin
                    e = exp_wr.pop_front();
                    check_eq("wr_addr", {28'd0, bus.ram_addr}, {28'd0, e.addr});
                    check_eq("wr_data", {8'd0, bus.ram_din}, {8'd0, e.data});
                end
            end
        end
    end

    function automatic logic [23:0] m_merge(input logic [23:0] w, input logic [1:0] sel, input logic [7:0] b);
        logic [23:0] mask;
        int unsigned sh;
        sh   = 8 * (3 - int'(sel));
        mask = 24'hFF << sh;
        return (w & ~mask) | (24'(b) << sh);
    endfunction

    // Drives one request for one cycle; returns #1 into the following cycle.
    task automatic issue(input logic we, input logic [1:0] sel, input logic [7:0] din, input bit track);
        wr_t e;
        bus.cpu_req = 1'b1;
        bus.cpu_we  = we;
        bus.cpu_sel = sel;
        bus.cpu_din = din;
        if (track) begin
            if (sel == 2'd0 && we) begin
                m_idx  = din[3:0];
                m_auto = din[7];
            end else if (sel == 2'd0) begin
                exp_rd.push_back({m_auto, 3'b000, m_idx});
            end else if (!we) begin
                exp_rd.push_back(8'(m_mem[m_idx] >> (8 * (3 - int'(sel)))));
            end else begin
                e.addr = m_idx;
                e.data = m_merge(m_mem[m_idx], sel, din);
                exp_wr.push_back(e);
                m_mem[m_idx] = e.data;
                if (sel == 2'd3 && m_auto) m_idx = m_idx + 4'd1;
            end
        end
        @(posedge clk);
        #1;
        bus.cpu_req = 1'b0;
    endtask

    task automatic run_lane(input logic we, input logic [1:0] sel, input logic [7:0] din,
                            output int busy_cycles, output int valid_cycle, output int we_delta);
        int we0;
        we0 = we_count;
        busy_cycles = 0;
        valid_cycle = 0;
        issue(we, sel, din, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            if (bus.cpu_busy) busy_cycles++;
            if (bus.cpu_dout_valid) valid_cycle = k;
            @(posedge clk);
            #1;
        end
        we_delta = we_count - we0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && bus.cpu_busy; i++) begin
            @(posedge clk);
            #1;
        end
        check_eq("idle_timeout", {31'd0, bus.cpu_busy}, 32'd0);
    endtask

    initial begin
        int bc, vc, wd;
        bus.cpu_req = 1'b0;
        bus.cpu_we  = 1'b0;
        bus.cpu_sel = 2'd0;
        bus.cpu_din = 8'd0;

        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            pre_en   = 1'b1;
            pre_addr = 4'(i);
            case (i)
                3:       pre_data = 24'h445566;
                5:       pre_data = 24'h112233;
                8:       pre_data = 24'hABCDEF;
                default: pre_data = 24'h010101 * 24'(i);
            endcase
            m_mem[i] = pre_data;
        end
        @(posedge clk);
        #1;
        pre_en = 1'b0;

        check_eq("rst_busy",    {31'd0, bus.cpu_busy}, 32'd0);
        check_eq("rst_dout",    {24'd0, bus.cpu_dout}, 32'd0);
        check_eq("rst_valid",   {31'd0, bus.cpu_dout_valid}, 32'd0);
        check_eq("rst_overrun", {31'd0, bus.cpu_overrun}, 32'd0);
        check_eq("rst_ram_we",  {31'd0, bus.ram_we}, 32'd0);
        check_eq("rst_addr",    {28'd0, bus.ram_addr}, 32'd0);
        check_eq("rst_din",     {8'd0, bus.ram_din}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single R write into entry 5
        issue(1'b1, 2'd0, 8'h05, 1'b1);
        check_eq("idx5_addr", {28'd0, bus.ram_addr}, 32'd5);
        run_lane(1'b1, 2'd1, 8'hAA, bc, vc, wd);
        check_eq("wr_busy_cycles", bc, 3);
        check_eq("wr_we_once", wd, 1);
        check_eq("mem5_after_r", {8'd0, mem[5]}, 32'h00AA2233);

        // Auto-increment across 15 -> 0
        issue(1'b1, 2'd0, 8'h8F, 1'b1);
        run_lane(1'b1, 2'd1, 8'h01, bc, vc, wd);
        run_lane(1'b1, 2'd2, 8'h02, bc, vc, wd);
        run_lane(1'b1, 2'd3, 8'h03, bc, vc, wd);
        check_eq("mem15", {8'd0, mem[15]}, 32'h00010203);
        check_eq("wrap_addr", {28'd0, bus.ram_addr}, 32'd0);
        issue(1'b0, 2'd0, 8'h00, 1'b1);
        @(posedge clk);
        #1;

        // Lane read of G at entry 5
        issue(1'b1, 2'd0, 8'h05, 1'b1);
        run_lane(1'b0, 2'd2, 8'h00, bc, vc, wd);
        check_eq("rd_busy_cycles", bc, 2);
        check_eq("rd_valid_cycle", vc, 3);
        check_eq("rd_no_we", wd, 0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("dout_hold", {24'd0, bus.cpu_dout}, 32'h22);

        // Overrun: request one cycle after a write is accepted
        issue(1'b1, 2'd1, 8'h77, 1'b1);
        bus.cpu_req = 1'b1;
        bus.cpu_we  = 1'b1;
        bus.cpu_sel = 2'd2;
        bus.cpu_din = 8'h99;
        @(posedge clk);
        #1;
        bus.cpu_req = 1'b0;
        wait_idle();
        @(posedge clk);
        #1;
        check_eq("overrun_set", {31'd0, bus.cpu_overrun}, 32'd1);
        check_eq("mem5_overrun", {8'd0, mem[5]}, 32'h00772233);
        issue(1'b1, 2'd0, 8'h05, 1'b1);
        check_eq("overrun_clr", {31'd0, bus.cpu_overrun}, 32'd0);

        // Reset during MRG of a write to entry 3
        issue(1'b1, 2'd0, 8'h03, 1'b1);
        issue(1'b1, 2'd2, 8'hEE, 1'b0);
        @(posedge clk);
        #1;
        check_eq("mrg_busy", {31'd0, bus.cpu_busy}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("mrg_rst_we",   {31'd0, bus.ram_we}, 32'd0);
        check_eq("mrg_rst_busy", {31'd0, bus.cpu_busy}, 32'd0);
        check_eq("mrg_rst_addr", {28'd0, bus.ram_addr}, 32'd0);
        m_idx  = '0;
        m_auto = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mem3_kept", {8'd0, mem[3]}, 32'h00445566);
        issue(1'b0, 2'd0, 8'h00, 1'b1);
        @(posedge clk);
        #1;

        // Back-to-back writes, second issued as busy falls
        issue(1'b1, 2'd0, 8'h08, 1'b1);
        issue(1'b1, 2'd1, 8'h10, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("b2b_busy_low", {31'd0, bus.cpu_busy}, 32'd0);
        issue(1'b1, 2'd2, 8'h20, 1'b1);
        check_eq("b2b_accepted", {31'd0, bus.cpu_busy}, 32'd1);
        wait_idle();
        @(posedge clk);
        #1;
        check_eq("mem8_b2b", {8'd0, mem[8]}, 32'h001020EF);
        check_eq("b2b_no_overrun", {31'd0, bus.cpu_overrun}, 32'd0);

        repeat (4) @(posedge clk);
        #1;
        check_eq("rd_queue_empty", exp_rd.size(), 0);
        check_eq("wr_queue_empty", exp_wr.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
